// File: rtl/mode_cmd_encoder.sv
// rtl/mode_cmd_encoder.sv - debounced push-button front end producing the ain mode/execute command bus
module mode_cmd_encoder #(
    parameter int DB_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_clr,
    input  logic       btn_tgl,
    input  logic       btn_set,
    input  logic       btn_go,
    output logic [1:0] ain,
    output logic [1:0] mode,
    output logic [7:0] exec_cnt
);

    localparam int            CW      = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    // Button lanes: 0 = clr, 1 = tgl, 2 = set, 3 = go
    logic [3:0]    raw;
    logic [3:0]    s1_q, s2_q;
    logic [3:0]    db_q, db_d;
    logic [3:0]    dly_q;
    logic [3:0]    rise;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];

    logic [1:0] ain_q, ain_d;
    logic [1:0] mode_q, mode_d;
    logic [7:0] exec_q, exec_d;
    logic [1:0] pend_q, pend_d;
    logic       pend_v_q, pend_v_d;

    logic [1:0] sel_code;
    logic       sel_v;

    assign raw  = {btn_go, btn_set, btn_tgl, btn_clr};
    assign rise = db_q & ~dly_q;

    // Debounce: count consecutive mismatch cycles, flip the level once DB_CYCLES have elapsed
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Synchronizer, debounce and edge-detect registers for all four buttons
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q  <= '0;
            s2_q  <= '0;
            db_q  <= '0;
            dly_q <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q  <= raw;
            s2_q  <= s1_q;
            db_q  <= db_d;
            dly_q <= db_q;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Select priority set > tgl > clr; lower-priority simultaneous presses are dropped
    always_comb begin
        sel_code = 2'b00;
        if (rise[2]) begin
            sel_code = 2'b11;
        end else if (rise[1]) begin
            sel_code = 2'b10;
        end else if (rise[0]) begin
            sel_code = 2'b01;
        end
        sel_v = |rise[2:0];
    end

    // Command sequencing: execute wins the cycle, a colliding select is parked one cycle
    always_comb begin
        ain_d    = mode_q;
        mode_d   = mode_q;
        exec_d   = exec_q;
        pend_d   = pend_q;
        pend_v_d = 1'b0;
        if (rise[3]) begin
            ain_d  = 2'b00;
            exec_d = exec_q + 8'd1;
            if (sel_v) begin
                pend_d   = sel_code;
                pend_v_d = 1'b1;
            end
        end else if (sel_v) begin
            // a fresh press is newer than anything parked, so it takes precedence
            mode_d = sel_code;
            ain_d  = sel_code;
        end else if (pend_v_q) begin
            mode_d = pend_q;
            ain_d  = pend_q;
        end
    end

    // Command state registers; ain resets asynchronously to the clear mode
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ain_q    <= 2'b01;
            mode_q   <= 2'b01;
            exec_q   <= 8'd0;
            pend_q   <= 2'b00;
            pend_v_q <= 1'b0;
        end else begin
            ain_q    <= ain_d;
            mode_q   <= mode_d;
            exec_q   <= exec_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
        end
    end

    assign ain      = ain_q;
    assign mode     = mode_q;
    assign exec_cnt = exec_q;

endmodule

// File: tb/tb_mode_cmd_encoder.sv
// tb/tb_mode_cmd_encoder.sv - scoreboard bench for mode_cmd_encoder
module tb_mode_cmd_encoder;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       btn_clr = 1'b0;
    logic       btn_tgl = 1'b0;
    logic       btn_set = 1'b0;
    logic       btn_go = 1'b0;
    logic [1:0] ain;
    logic [1:0] mode;
    logic [7:0] exec_cnt;

    mode_cmd_encoder #(.DB_CYCLES(16)) dut (
        .clock    (clock),
        .reset    (reset),
        .btn_clr  (btn_clr),
        .btn_tgl  (btn_tgl),
        .btn_set  (btn_set),
        .btn_go   (btn_go),
        .ain      (ain),
        .mode     (mode),
        .exec_cnt (exec_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        logic [11:0] val;
    } ev_t;

    ev_t         q[$];
    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;
    logic [11:0] prev = 12'h0;
    logic [11:0] cur;
    ev_t         e;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every change of {ain, mode, exec_cnt} is an output event checked against the queue
    always @(negedge clock) begin
        cur = {ain, mode, exec_cnt};
        if (reset) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                $display("FAIL missed_event: expected ain/mode/exec=%h at cycle %0d, no change seen (now %0d)",
                         q[0].val, q[0].cyc, cyc);
                void'(q.pop_front());
            end
            if (cur != prev) begin
                checks++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_event: ain/mode/exec=%h at cycle %0d, required no change", cur, cyc);
                end else begin
                    e = q.pop_front();
                    if (e.cyc == cyc && e.val == cur) begin
                        passes++;
                    end else begin
                        $display("FAIL event: got ain/mode/exec=%h at cycle %0d, required %h at cycle %0d",
                                 cur, cyc, e.val, e.cyc);
                    end
                end
            end
        end
        prev = cur;
    end

    task automatic expect_ev(input int at, input logic [1:0] a, input logic [1:0] m, input logic [7:0] x);
        ev_t n;
        n.cyc = at;
        n.val = {a, m, x};
        q.push_back(n);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic waitn(input int n);
        repeat (n) @(negedge clock);
    endtask

    // mask = {go, set, tgl, clr}
    task automatic drive(input logic [3:0] mask);
        {btn_go, btn_set, btn_tgl, btn_clr} = mask;
    endtask

    task automatic press(input logic [3:0] mask, input int hold, input int gap);
        drive(mask);
        waitn(hold);
        drive(4'b0000);
        waitn(gap);
    endtask

    int c;
    int r;

    initial begin
        // reset and idle
        waitn(3);
        chk("reset_ain", ain, 1);
        chk("reset_mode", mode, 1);
        chk("reset_exec", exec_cnt, 0);
        reset = 1'b1;
        waitn(100);
        chk("idle_ain", ain, 1);
        chk("idle_mode", mode, 1);
        chk("idle_exec", exec_cnt, 0);

        // select set, then execute
        c = cyc; expect_ev(c + 19, 2'b11, 2'b11, 8'd0);
        press(4'b0100, 25, 25);
        c = cyc; expect_ev(c + 19, 2'b00, 2'b11, 8'd1); expect_ev(c + 20, 2'b11, 2'b11, 8'd1);
        press(4'b1000, 25, 25);

        // bouncing toggle is rejected, then a clean hold is accepted once
        for (int i = 0; i < 12; i++) begin
            btn_tgl = (i % 2 == 0);
            waitn(5);
        end
        btn_tgl = 1'b0;
        waitn(20);
        chk("bounce_mode", mode, 3);
        c = cyc; expect_ev(c + 19, 2'b10, 2'b10, 8'd1);
        press(4'b0010, 25, 25);

        // back to set, then go and clr together
        c = cyc; expect_ev(c + 19, 2'b11, 2'b11, 8'd1);
        press(4'b0100, 25, 25);
        c = cyc; expect_ev(c + 19, 2'b00, 2'b11, 8'd2); expect_ev(c + 20, 2'b01, 2'b01, 8'd2);
        press(4'b1001, 25, 25);

        // 256 executes wrap the counter through 255 -> 0 back to 2
        for (int k = 1; k <= 256; k++) begin
            c = cyc;
            expect_ev(c + 19, 2'b00, 2'b01, 8'((2 + k) % 256));
            expect_ev(c + 20, 2'b01, 2'b01, 8'((2 + k) % 256));
            press(4'b1000, 20, 20);
        end
        chk("wrap_exec", exec_cnt, 2);

        // set and clr together: set wins
        c = cyc; expect_ev(c + 19, 2'b11, 2'b11, 8'd2);
        press(4'b0101, 25, 25);

        // reset during the execute pulse, go held through release
        c = cyc; expect_ev(c + 19, 2'b00, 2'b11, 8'd3);
        drive(4'b1000);
        waitn(19);
        chk("pulse_ain", ain, 0);
        #2 reset = 1'b0;
        #1;
        chk("async_ain", ain, 1);
        chk("async_mode", mode, 1);
        chk("async_exec", exec_cnt, 0);
        waitn(3);
        reset = 1'b1;
        r = cyc;
        expect_ev(r + 19, 2'b00, 2'b01, 8'd1);
        expect_ev(r + 20, 2'b01, 2'b01, 8'd1);
        waitn(25);
        drive(4'b0000);
        waitn(40);

        chk("queue_drained", q.size(), 0);
        chk("final_exec", exec_cnt, 1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
